// File: rtl/enet_pkg.sv
// Shared types and constants for the Ethernet receive path.
package enet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    DRAIN,
    WAIT_DONE,
    HOLD
  } rx_state_t;

  // Header word offsets (16-bit words): destination MAC, source MAC, EtherType
  localparam int unsigned DST_OFF = 0;
  localparam int unsigned SRC_OFF = 3;
  localparam int unsigned TYPE_OFF = 6;

  // Shortest frame that still carries a full header
  localparam logic [11:0] MIN_LEN = 12'(2 * (TYPE_OFF + 1));

  localparam logic [15:0] BCAST_WORD = 16'hFFFF;

  // Word idx of a MAC as it appears on the bus: low byte is the earlier wire byte
  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [1:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    case (idx)
      2'd0:    w = {mac[39:32], mac[47:40]};
      2'd1:    w = {mac[23:16], mac[31:24]};
      default: w = {mac[7:0], mac[15:8]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rx_word_buffer.sv
// Packet word store: one write port, one registered read port.
module rx_word_buffer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  logic [15:0] mem [DEPTH];

  // Word storage; contents deliberately survive reset
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, one cycle latency
  always_ff @(posedge Clock) begin
    if (Reset) rd_data <= 16'h0000;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_packet_sink.sv
// Receive-side client of the packet interface: buffers a packet, filters on
// destination MAC, holds accepted packets for a reader and counts good/drop.
module rx_packet_sink
  import enet_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [47:0] MY_MAC    = 48'h00_12_34_56_78_9A
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              rx_packet_rdy_in,
  input  logic [11:0]       rx_len_in,
  output logic              rx_req_out,
  input  logic              rx_data_valid_in,
  input  logic [15:0]       rx_packet_data_in,
  input  logic              rx_complete_in,
  output logic              pkt_valid_out,
  output logic [ADDR_W:0]   pkt_words_out,
  input  logic [ADDR_W-1:0] buf_rd_addr_in,
  output logic [15:0]       buf_rd_data_out,
  input  logic              pkt_release_in,
  output logic [7:0]        good_count_out,
  output logic [7:0]        drop_count_out,
  output logic [8:0]        Debug_LEDG
);

  localparam int unsigned CNT_W = 12;

  rx_state_t         state;
  logic [11:0]       len_q;
  logic [CNT_W-1:0]  exp_words;
  logic [CNT_W-1:0]  word_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              mac_uc;
  logic              mac_bc;
  logic              ovf;
  logic              drop_seen;

  logic              take_word_c;
  logic              store_word_c;
  logic              mac_uc_c;
  logic              mac_bc_c;
  logic              ovf_c;
  logic              accept_c;
  logic [CNT_W-1:0]  word_cnt_c;
  logic [CNT_W-1:0]  exp_words_c;
  logic [15:0]       my_word_c;

  assign rx_req_out = (state == RECEIVE) || (state == DRAIN);
  assign Debug_LEDG = {drop_seen, good_count_out};

  // Packet status including the word presented this cycle, so a word that
  // arrives with rx_complete_in is counted before the accept decision
  always_comb begin
    exp_words_c  = CNT_W'((13'(rx_len_in) + 13'd1) >> 1);
    take_word_c  = rx_req_out && rx_data_valid_in;
    store_word_c = take_word_c && (state == RECEIVE);
    word_cnt_c   = word_cnt + CNT_W'(take_word_c);
    my_word_c    = mac_word(MY_MAC, 2'(word_cnt[1:0] - 2'(DST_OFF)));
    mac_uc_c     = mac_uc;
    mac_bc_c     = mac_bc;
    if (store_word_c && (word_cnt < CNT_W'(SRC_OFF))) begin
      if (rx_packet_data_in != my_word_c)  mac_uc_c = 1'b0;
      if (rx_packet_data_in != BCAST_WORD) mac_bc_c = 1'b0;
    end
    ovf_c    = ovf || (take_word_c && (state == DRAIN));
    accept_c = (mac_uc_c || mac_bc_c) && !ovf_c &&
               (word_cnt_c == exp_words) && (len_q >= MIN_LEN);
  end

  // Receive FSM, filter flags, hold handshake and statistics
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= IDLE;
      len_q          <= '0;
      exp_words      <= '0;
      word_cnt       <= '0;
      wr_ptr         <= '0;
      mac_uc         <= 1'b0;
      mac_bc         <= 1'b0;
      ovf            <= 1'b0;
      drop_seen      <= 1'b0;
      pkt_valid_out  <= 1'b0;
      pkt_words_out  <= '0;
      good_count_out <= '0;
      drop_count_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_packet_rdy_in) begin
            len_q     <= rx_len_in;
            exp_words <= exp_words_c;
            word_cnt  <= '0;
            wr_ptr    <= '0;
            mac_uc    <= 1'b1;
            mac_bc    <= 1'b1;
            ovf       <= 1'b0;
            state     <= (exp_words_c == '0) ? WAIT_DONE : RECEIVE;
          end
        end
        RECEIVE, DRAIN, WAIT_DONE: begin
          word_cnt <= word_cnt_c;
          mac_uc   <= mac_uc_c;
          mac_bc   <= mac_bc_c;
          ovf      <= ovf_c;
          if (store_word_c) wr_ptr <= wr_ptr + ADDR_W'(1);
          if (rx_complete_in) begin
            if (accept_c) begin
              state         <= HOLD;
              pkt_valid_out <= 1'b1;
              pkt_words_out <= word_cnt_c[ADDR_W:0];
              if (good_count_out != 8'hFF) good_count_out <= good_count_out + 8'd1;
            end else begin
              state     <= IDLE;
              drop_seen <= 1'b1;
              if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
            end
          end else if (take_word_c) begin
            if (word_cnt_c == exp_words) begin
              state <= WAIT_DONE;
            end else if (store_word_c && (wr_ptr == ADDR_W'(BUF_DEPTH - 1))) begin
              state <= DRAIN;
            end
          end
        end
        HOLD: begin
          if (pkt_release_in) begin
            state         <= IDLE;
            pkt_valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_word_buffer #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (store_word_c),
    .wr_addr (wr_ptr),
    .wr_data (rx_packet_data_in),
    .rd_addr (buf_rd_addr_in),
    .rd_data (buf_rd_data_out)
  );

endmodule

// File: tb/tb_rx_packet_sink.sv
// Randomized packet-level bench for rx_packet_sink with a per-cycle output compare.
module tb_rx_packet_sink;

  localparam logic [47:0] MY_MAC = 48'h00_12_34_56_78_9A;
  localparam logic [47:0] BC_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER_MAC = 48'h00_11_22_33_44_55;
  localparam int DEPTH = 32;

  logic        Clock;
  logic        Reset;
  logic        rx_packet_rdy_in;
  logic [11:0] rx_len_in;
  logic        rx_req_out;
  logic        rx_data_valid_in;
  logic [15:0] rx_packet_data_in;
  logic        rx_complete_in;
  logic        pkt_valid_out;
  logic [5:0]  pkt_words_out;
  logic [4:0]  buf_rd_addr_in;
  logic [15:0] buf_rd_data_out;
  logic        pkt_release_in;
  logic [7:0]  good_count_out;
  logic [7:0]  drop_count_out;
  logic [8:0]  Debug_LEDG;

  rx_packet_sink dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .rx_packet_rdy_in  (rx_packet_rdy_in),
    .rx_len_in         (rx_len_in),
    .rx_req_out        (rx_req_out),
    .rx_data_valid_in  (rx_data_valid_in),
    .rx_packet_data_in (rx_packet_data_in),
    .rx_complete_in    (rx_complete_in),
    .pkt_valid_out     (pkt_valid_out),
    .pkt_words_out     (pkt_words_out),
    .buf_rd_addr_in    (buf_rd_addr_in),
    .buf_rd_data_out   (buf_rd_data_out),
    .pkt_release_in    (pkt_release_in),
    .good_count_out    (good_count_out),
    .drop_count_out    (drop_count_out),
    .Debug_LEDG        (Debug_LEDG)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-output state, maintained at packet granularity
  bit          chk_en = 1'b0;
  logic        exp_req;
  logic        exp_valid;
  logic [5:0]  exp_pw;
  int          exp_good;
  int          exp_drop;
  bit          exp_sticky;
  bit          rd_chk = 1'b0;
  logic [15:0] exp_rd;
  logic [15:0] bufm [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare every output against the model on the falling edge
  always @(negedge Clock) begin
    if (chk_en) begin
      check("rx_req_out", 32'(rx_req_out), 32'(exp_req));
      check("pkt_valid_out", 32'(pkt_valid_out), 32'(exp_valid));
      if (exp_valid) check("pkt_words_out", 32'(pkt_words_out), 32'(exp_pw));
      check("good_count_out", 32'(good_count_out), 32'(exp_good));
      check("drop_count_out", 32'(drop_count_out), 32'(exp_drop));
      check("Debug_LEDG", 32'(Debug_LEDG), 32'({exp_sticky, 8'(exp_good)}));
      if (rd_chk) check("buf_rd_data_out", 32'(buf_rd_data_out), 32'(exp_rd));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: no finish after %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Wire-order MAC word j: byte 2j in the low half, byte 2j+1 in the high half
  function automatic logic [15:0] wire_word(input logic [47:0] mac, input int j);
    logic [7:0] b [6];
    for (int k = 0; k < 6; k++) b[k] = mac[47-8*k -: 8];
    return {b[2*j+1], b[2*j]};
  endfunction

  // Offer one packet, present n_words words, then end it; update the model
  task automatic send_packet(input int len, input logic [47:0] dst, input int n_words,
                             input bit cmpl_last, input int max_gap);
    int ew;
    int got;
    bit with_word;
    bit acc;
    logic [15:0] w [$];
    ew = (len + 1) / 2;
    for (int i = 0; i < n_words; i++)
      w.push_back((i < 3) ? wire_word(dst, i) : 16'($urandom));
    with_word = cmpl_last && (n_words > 0);
    rx_len_in = 12'(len);
    rx_packet_rdy_in = 1'b1;
    tick();
    rx_packet_rdy_in = 1'b0;
    rx_len_in = 12'($urandom);
    exp_req = (ew != 0);
    got = 0;
    for (int i = 0; i < n_words; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        rx_data_valid_in = 1'b0;
        rx_packet_data_in = 16'($urandom);
        tick();
      end
      rx_data_valid_in = 1'b1;
      rx_packet_data_in = w[i];
      rx_complete_in = with_word && (i == n_words - 1);
      tick();
      got++;
      if (got == ew) exp_req = 1'b0;
    end
    rx_data_valid_in = 1'b0;
    if (!with_word) begin
      repeat ($urandom_range(0, max_gap)) begin
        rx_data_valid_in = exp_req ? 1'b0 : 1'($urandom);
        rx_packet_data_in = 16'($urandom);
        tick();
      end
      rx_data_valid_in = 1'b0;
      rx_complete_in = 1'b1;
      tick();
    end
    rx_complete_in = 1'b0;
    for (int i = 0; i < n_words && i < DEPTH; i++) bufm[i] = w[i];
    acc = (got == ew) && (ew <= DEPTH) && (len >= 14) && ((dst == MY_MAC) || (dst == BC_MAC));
    exp_req = 1'b0;
    if (acc) begin
      exp_valid = 1'b1;
      exp_pw = 6'(got);
      if (exp_good < 255) exp_good++;
    end else begin
      if (exp_drop < 255) exp_drop++;
      exp_sticky = 1'b1;
    end
  endtask

  // Optionally read the held packet back, poke ignored inputs, then release
  task automatic hold_and_release(input bit readback);
    int n;
    n = int'(exp_pw);
    if (readback) begin
      for (int a = 0; a < n; a++) begin
        buf_rd_addr_in = 5'(a);
        tick();
        exp_rd = bufm[a];
        rd_chk = 1'b1;
      end
      tick();
      rd_chk = 1'b0;
    end
    repeat ($urandom_range(0, 3)) begin
      rx_packet_rdy_in = 1'($urandom);
      rx_len_in = 12'($urandom_range(14, 60));
      rx_complete_in = 1'($urandom);
      rx_data_valid_in = 1'($urandom);
      rx_packet_data_in = 16'($urandom);
      tick();
    end
    rx_packet_rdy_in = 1'b0;
    rx_complete_in = 1'b0;
    rx_data_valid_in = 1'b0;
    pkt_release_in = 1'b1;
    tick();
    pkt_release_in = 1'b0;
    exp_valid = 1'b0;
  endtask

  // Stray strobes while idle must not disturb anything
  task automatic idle_junk();
    repeat ($urandom_range(0, 2)) begin
      rx_complete_in = 1'($urandom);
      rx_data_valid_in = 1'($urandom);
      rx_packet_data_in = 16'($urandom);
      tick();
    end
    rx_complete_in = 1'b0;
    rx_data_valid_in = 1'b0;
  endtask

  task automatic finish_pkt();
    if (exp_valid) hold_and_release(1'($urandom));
    idle_junk();
  endtask

  initial begin
    int len;
    int ew;
    int n;
    logic [47:0] dst;
    Reset = 1'b1;
    rx_packet_rdy_in = 1'b0;
    rx_len_in = 12'd0;
    rx_data_valid_in = 1'b0;
    rx_packet_data_in = 16'h0000;
    rx_complete_in = 1'b0;
    buf_rd_addr_in = 5'd0;
    pkt_release_in = 1'b0;
    exp_req = 1'b0;
    exp_valid = 1'b0;
    exp_pw = 6'd0;
    exp_good = 0;
    exp_drop = 0;
    exp_sticky = 1'b0;
    exp_rd = 16'h0000;
    tick();
    tick();
    chk_en = 1'b1;
    Reset = 1'b0;
    tick();

    // Unicast 64 bytes, readback
    send_packet(64, MY_MAC, 32, 1'b1, 1);
    check("t1_pkt_words", 32'(pkt_words_out), 32'd32);
    check("t1_good", 32'(good_count_out), 32'd1);
    hold_and_release(1'b1);

    // Broadcast 60 bytes
    send_packet(60, BC_MAC, 30, 1'b0, 2);
    check("t2_good", 32'(good_count_out), 32'd2);
    hold_and_release(1'b0);
    check("t2_released", 32'(pkt_valid_out), 32'd0);

    // Foreign destination
    send_packet(64, OTHER_MAC, 32, 1'b1, 0);
    check("t3_drop", 32'(drop_count_out), 32'd1);
    check("t3_sticky", 32'(Debug_LEDG[8]), 32'd1);
    check("t3_no_pkt", 32'(pkt_valid_out), 32'd0);

    // Overflow: 50 words, 18 drained
    send_packet(100, MY_MAC, 50, 1'b0, 1);
    check("t4_drop", 32'(drop_count_out), 32'd2);

    // Short packet and zero length
    send_packet(60, MY_MAC, 10, 1'b0, 1);
    send_packet(0, MY_MAC, 0, 1'b0, 2);
    check("t5_drop", 32'(drop_count_out), 32'd4);

    // Length boundaries
    send_packet(13, MY_MAC, 7, 1'b1, 0);
    send_packet(14, MY_MAC, 7, 1'b1, 0);
    finish_pkt();
    send_packet(65, MY_MAC, 33, 1'b1, 0);
    send_packet(63, BC_MAC, 32, 1'b0, 0);
    check("t6_words", 32'(pkt_words_out), 32'd32);
    finish_pkt();

    // Random traffic
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(0, 80);
      ew = (len + 1) / 2;
      case ($urandom_range(0, 2))
        0:       dst = MY_MAC;
        1:       dst = BC_MAC;
        default: dst = 48'({$urandom, $urandom});
      endcase
      n = ($urandom_range(0, 3) != 0) ? ew : $urandom_range(0, ew);
      send_packet(len, dst, n, 1'($urandom), 2);
      finish_pkt();
    end

    // Reset in the middle of a packet
    rx_len_in = 12'd40;
    rx_packet_rdy_in = 1'b1;
    tick();
    rx_packet_rdy_in = 1'b0;
    exp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data_valid_in = 1'b1;
      rx_packet_data_in = wire_word(MY_MAC, i % 3);
      tick();
    end
    Reset = 1'b1;
    tick();
    exp_req = 1'b0;
    exp_valid = 1'b0;
    exp_good = 0;
    exp_drop = 0;
    exp_sticky = 1'b0;
    rx_data_valid_in = 1'b0;
    check("rst_req", 32'(rx_req_out), 32'd0);
    check("rst_good", 32'(good_count_out), 32'd0);
    check("rst_drop", 32'(drop_count_out), 32'd0);
    Reset = 1'b0;
    tick();

    // Good counter saturation
    repeat (256) begin
      send_packet(14, MY_MAC, 7, 1'b1, 0);
      hold_and_release(1'b0);
    end
    check("sat_good", 32'(good_count_out), 32'd255);
    send_packet(14, MY_MAC, 7, 1'b1, 0);
    check("sat_good_hold", 32'(good_count_out), 32'd255);
    hold_and_release(1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
